fft16_seq_ctrl: RTL and testbench

//  Sequencer for a 16-point radix-2 DIF FFT built on one shared butterfly_base_16bits instance.

---
 rtl/fft16_pkg.sv | 39 +++
 rtl/fft16_seq_ctrl_butterfly.sv | 57 +++++
 rtl/fft16_seq_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_fft16_seq_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft16_pkg.sv
// ---------------------------------------------------------------------------
// fft16_pkg
// Shared definitions for the 16-point radix-2 DIF FFT sequencer:
//   state_t        : sequencer states IDLE / LOAD / CALC / OUT
//   N, LOG2N       : transform size and address width
//   W_REAL, W_IMAG : twiddle factors W^k = cos(2*pi*k/16) - j*sin(2*pi*k/16),
//                    k = 0..7, as signed Q16 values in 32 bits
//   bitrev4()      : 4-bit bit reversal, maps a frequency bin to its
//                    memory slot after the in-place DIF passes
// ---------------------------------------------------------------------------
package fft16_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC,
    OUT
  } state_t;

  localparam int N     = 16;
  localparam int LOG2N = 4;

  // Q16 cosines, rounded to nearest: 65536, 60547, 46341, 25080, 0, ...
  localparam logic signed [31:0] W_REAL [0:7] = '{
    32'sh0001_0000, 32'sh0000_EC83, 32'sh0000_B505, 32'sh0000_61F8,
    32'sh0000_0000, 32'shFFFF_9E08, 32'shFFFF_4AFB, 32'shFFFF_137D
  };

  // Q16 negated sines: 0, -25080, -46341, -60547, -65536, ...
  localparam logic signed [31:0] W_IMAG [0:7] = '{
    32'sh0000_0000, 32'shFFFF_9E08, 32'shFFFF_4AFB, 32'shFFFF_137D,
    32'shFFFF_0000, 32'shFFFF_137D, 32'shFFFF_4AFB, 32'shFFFF_9E08
  };

  function automatic logic [3:0] bitrev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

endpackage

// File: rtl/fft16_seq_ctrl_butterfly.sv
// ---------------------------------------------------------------------------
// butterfly_base_16bits
// Combinational radix-2 DIF butterfly on 16-bit signed complex data.
//   x_real/x_imag, y_real/y_imag : input pair (signed 16-bit)
//   w_real/w_imag                : twiddle factor, signed Q16 in 32 bits
//   a_real/a_imag                : upper 16 bits of (X + Y) * 2^16
//   b_real/b_imag                : upper 16 bits of (X - Y) * W
// All arithmetic wraps at 32 bits; there is no saturation.
// Build option: FFT16_ROUND_EN adds 0x0000_8000 to each 32-bit result before
// the upper half is taken (round half up); otherwise results are truncated.
// ---------------------------------------------------------------------------
module butterfly_base_16bits (
  input  logic signed [15:0] x_real,
  input  logic signed [15:0] x_imag,
  input  logic signed [15:0] y_real,
  input  logic signed [15:0] y_imag,
  input  logic signed [31:0] w_real,
  input  logic signed [31:0] w_imag,
  output logic signed [15:0] a_real,
  output logic signed [15:0] a_imag,
  output logic signed [15:0] b_real,
  output logic signed [15:0] b_imag
);

`ifdef FFT16_ROUND_EN
  localparam logic [31:0] RND = 32'h0000_8000;
`else
  localparam logic [31:0] RND = 32'h0000_0000;
`endif

  logic signed [16:0] dif_r;
  logic signed [16:0] dif_i;
  logic signed [31:0] prod_r;
  logic signed [31:0] prod_i;
  logic        [31:0] b_r32;
  logic        [31:0] b_i32;

  // The sum path is (X+Y) placed in the upper half with a zero lower half, so
  // adding the rounding constant can never carry into bits [31:16]; the upper
  // half is simply the wrapped 16-bit sum in both build variants.
  // The difference path keeps 17 bits so the complex multiply sees the exact
  // difference; only the low 32 bits of each product matter, so the products
  // are formed directly at 32 bits.
  always_comb begin
    a_real = x_real + y_real;
    a_imag = x_imag + y_imag;
    dif_r  = 17'(x_real) - 17'(y_real);
    dif_i  = 17'(x_imag) - 17'(y_imag);
    prod_r = 32'(dif_r) * w_real - 32'(dif_i) * w_imag;
    prod_i = 32'(dif_r) * w_imag + 32'(dif_i) * w_real;
    b_r32  = prod_r + RND;
    b_i32  = prod_i + RND;
    b_real = 16'(b_r32 >> 16);
    b_imag = 16'(b_i32 >> 16);
  end

endmodule

// File: rtl/fft16_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fft16_seq_ctrl
// Sequencer for a 16-point radix-2 DIF FFT built on one shared
// butterfly_base_16bits. Loads 16 complex samples, runs 4 stages x 8
// butterflies in place (one per cycle), then streams 16 results out.
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   din_valid/din_ready   : input handshake; din_real/din_imag signed samples
//   dout_valid/dout_ready : output handshake; dout_real/dout_imag results
//   dout_idx              : frequency bin of the result on dout_*
//   done                  : one-cycle pulse when bin 15 is accepted
// Parameters:
//   DATA_W     : sample width, only 16 is supported
//   BITREV_OUT : 0 natural bin order, 1 raw memory (bit-reversed) order
// Build option: FFT16_ROUND_EN enables rounding inside the butterfly.
// ---------------------------------------------------------------------------
module fft16_seq_ctrl
  import fft16_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter bit BITREV_OUT = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     din_valid,
  output logic                     din_ready,
  input  logic signed [DATA_W-1:0] din_real,
  input  logic signed [DATA_W-1:0] din_imag,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic signed [DATA_W-1:0] dout_real,
  output logic signed [DATA_W-1:0] dout_imag,
  output logic [3:0]               dout_idx,
  output logic                     done
);

  state_t state;
  state_t state_next;

  logic [LOG2N-1:0] in_cnt;
  logic [LOG2N-1:0] out_idx;
  logic [LOG2N:0]   calc_cnt;

  logic signed [DATA_W-1:0] mem_real [0:N-1];
  logic signed [DATA_W-1:0] mem_imag [0:N-1];

  logic             in_fire;
  logic             out_fire;
  logic [1:0]       stage;
  logic [2:0]       bfly;
  logic [LOG2N-1:0] top_addr;
  logic [LOG2N-1:0] bot_addr;
  logic [2:0]       tw_idx;
  logic [LOG2N-1:0] out_addr;

  logic signed [DATA_W-1:0] a_real;
  logic signed [DATA_W-1:0] a_imag;
  logic signed [DATA_W-1:0] b_real;
  logic signed [DATA_W-1:0] b_imag;

  // State register; an asserted reset abandons whatever frame is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode. Sample 0 is taken in IDLE on the same
  // edge that moves to LOAD, so LOAD leaves after the 16th accepted sample.
  // done is the acceptance of bin 15, which is also the exit from OUT.
  always_comb begin
    state_next = state;
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    case (state)
      IDLE: begin
        din_ready = 1'b1;
        if (din_valid) state_next = LOAD;
      end
      LOAD: begin
        din_ready = 1'b1;
        if (din_valid && in_cnt == 4'd15) state_next = CALC;
      end
      CALC: begin
        if (calc_cnt == 5'd31) state_next = OUT;
      end
      OUT: begin
        dout_valid = 1'b1;
        if (dout_ready && out_idx == 4'd15) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    in_fire  = din_valid & din_ready;
    out_fire = dout_valid & dout_ready;
    done     = out_fire && (out_idx == 4'd15);
  end

  // Butterfly addressing. calc_cnt is {stage, butterfly}; the group base is
  // (k >> (3-s)) * 2 * span and the offset k & (span-1), which for each stage
  // reduces to inserting a zero at the span bit position of k. The twiddle
  // index is the offset scaled by 2^s.
  always_comb begin
    stage    = calc_cnt[4:3];
    bfly     = calc_cnt[2:0];
    top_addr = '0;
    tw_idx   = '0;
    case (stage)
      2'd0: begin
        top_addr = {1'b0, bfly};
        tw_idx   = bfly;
      end
      2'd1: begin
        top_addr = {bfly[2], 1'b0, bfly[1:0]};
        tw_idx   = {bfly[1:0], 1'b0};
      end
      2'd2: begin
        top_addr = {bfly[2:1], 1'b0, bfly[0]};
        tw_idx   = {bfly[0], 2'b00};
      end
      default: begin
        top_addr = {bfly, 1'b0};
        tw_idx   = 3'd0;
      end
    endcase
    bot_addr = top_addr | (4'd8 >> stage);
  end

  butterfly_base_16bits u_bfly (
    .x_real (mem_real[top_addr]),
    .x_imag (mem_imag[top_addr]),
    .y_real (mem_real[bot_addr]),
    .y_imag (mem_imag[bot_addr]),
    .w_real (W_REAL[tw_idx]),
    .w_imag (W_IMAG[tw_idx]),
    .a_real (a_real),
    .a_imag (a_imag),
    .b_real (b_real),
    .b_imag (b_imag)
  );

  // Sample, butterfly and output counters. Each wraps to zero exactly at the
  // end of its phase, so the next frame always starts from a clean count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt   <= '0;
      calc_cnt <= '0;
      out_idx  <= '0;
    end else begin
      if (in_fire)       in_cnt   <= in_cnt + 4'd1;
      if (state == CALC) calc_cnt <= calc_cnt + 5'd1;
      if (out_fire)      out_idx  <= out_idx + 4'd1;
    end
  end

  // Working buffer. Loading and butterfly write-back never overlap because
  // din_ready is low during CALC; each butterfly result lands on its own
  // top/bottom slots at the end of its cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        mem_real[i] <= '0;
        mem_imag[i] <= '0;
      end
    end else if (in_fire) begin
      mem_real[in_cnt] <= din_real;
      mem_imag[in_cnt] <= din_imag;
    end else if (state == CALC) begin
      mem_real[top_addr] <= a_real;
      mem_imag[top_addr] <= a_imag;
      mem_real[bot_addr] <= b_real;
      mem_imag[bot_addr] <= b_imag;
    end
  end

  // Output read. DIF leaves bins bit-reversed in memory, so natural order
  // reads slot bitrev4(idx). Data is forced to zero outside OUT.
  always_comb begin
    out_addr  = BITREV_OUT ? out_idx : bitrev4(out_idx);
    dout_idx  = out_idx;
    dout_real = dout_valid ? mem_real[out_addr] : '0;
    dout_imag = dout_valid ? mem_imag[out_addr] : '0;
  end

endmodule

// File: tb/tb_fft16_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fft16_seq_ctrl
// Directed bench for fft16_seq_ctrl: reset values, impulse, DC, Nyquist and a
// quarter-rate impulse (exercises the -j twiddle and bit-reversed readout),
// handshake latency, consumer backpressure and a mid-frame reset.
// All frames used produce exact results, so expectations hold with or without
// FFT16_ROUND_EN.
// ---------------------------------------------------------------------------
module tb_fft16_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [15:0] din_real = '0;
  logic [15:0] din_imag = '0;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic [15:0] dout_real;
  logic [15:0] dout_imag;
  logic [3:0]  dout_idx;
  logic        done;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  logic [15:0] frame_re [16];
  logic [15:0] frame_im [16];
  logic [15:0] res_re [16];
  logic [15:0] res_im [16];
  logic [3:0]  res_idx [16];
  logic        res_done [16];
  int          got;
  int          first_valid_cyc;
  int          t_accept;
  int          ready_leak;
  int          done_cnt;
  int          not_ready;
  bit          timed_out;

  fft16_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din_real   (din_real),
    .din_imag   (din_imag),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_real  (dout_real),
    .dout_imag  (dout_imag),
    .dout_idx   (dout_idx),
    .done       (done)
  );

  // 10 ns clock; cyc counts rising edges so latencies can be measured.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic load_impulse(input int pos);
    for (int i = 0; i < 16; i++) begin
      frame_re[i] = (i == pos) ? 16'h0100 : 16'h0000;
      frame_im[i] = 16'h0000;
    end
  endtask

  task automatic load_dc();
    for (int i = 0; i < 16; i++) begin
      frame_re[i] = 16'h0100;
      frame_im[i] = 16'h0000;
    end
  endtask

  task automatic load_nyquist();
    for (int i = 0; i < 16; i++) begin
      frame_re[i] = (i % 2 == 0) ? 16'h0100 : 16'hFF00;
      frame_im[i] = 16'h0000;
    end
  endtask

  // Impulse at n=4: X[k] = 0x100 * (-j)^k.
  function automatic logic [31:0] quarter_bin(input int k);
    case (k % 4)
      0:       return {16'h0100, 16'h0000};
      1:       return {16'h0000, 16'hFF00};
      2:       return {16'hFF00, 16'h0000};
      default: return {16'h0000, 16'h0100};
    endcase
  endfunction

  // Drives one sample per cycle. On return we are at the falling edge right
  // after the last transfer; t_accept holds cyc there (cycle T+1).
  task automatic send_frame();
    not_ready = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (!din_ready) not_ready++;
      din_valid = 1'b1;
      din_real  = frame_re[i];
      din_imag  = frame_im[i];
    end
    @(negedge clk);
    din_valid = 1'b0;
    din_real  = '0;
    din_imag  = '0;
    t_accept  = cyc;
  endtask

  // Collects 16 results with dout_ready held high, bounded by 100 cycles.
  task automatic collect_frame();
    int waited = 0;
    got = 0;
    timed_out = 1'b0;
    first_valid_cyc = -1;
    ready_leak = 0;
    done_cnt = 0;
    dout_ready = 1'b1;
    while (got < 16) begin
      @(negedge clk);
      waited++;
      if (din_ready) ready_leak++;
      if (done) done_cnt++;
      if (dout_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        res_re[got]   = dout_real;
        res_im[got]   = dout_imag;
        res_idx[got]  = dout_idx;
        res_done[got] = done;
        got++;
      end
      if (waited > 100) begin
        timed_out = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (din_ready !== 1'b1) $display("[TB] FAIL reset_din_ready: got %b want 1", din_ready);
    else passed++;
    checks++;
    if (dout_valid !== 1'b0) $display("[TB] FAIL reset_dout_valid: got %b want 0", dout_valid);
    else passed++;
    checks++;
    if ({dout_real, dout_imag} !== 32'h0)
      $display("[TB] FAIL reset_dout_data: got %h want 00000000", {dout_real, dout_imag});
    else passed++;
    checks++;
    if ({dout_idx, done} !== 5'b0)
      $display("[TB] FAIL reset_idx_done: got %b want 00000", {dout_idx, done});
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_impulse();
    load_impulse(0);
    send_frame();
    collect_frame();
    checks++;
    if (timed_out) $display("[TB] FAIL impulse_timeout: got %0d results want 16", got);
    else passed++;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({res_idx[i], res_re[i], res_im[i]} !== {4'(i), 16'h0100, 16'h0000})
        $display("[TB] FAIL impulse_bin%0d: got idx %0d %h/%h want idx %0d 0100/0000",
                 i, res_idx[i], res_re[i], res_im[i], i);
      else passed++;
    end
  endtask

  task automatic test_dc();
    load_dc();
    send_frame();
    collect_frame();
    checks++;
    if (timed_out) $display("[TB] FAIL dc_timeout: got %0d results want 16", got);
    else passed++;
    for (int i = 0; i < 16; i++) begin
      logic [15:0] exp_re;
      exp_re = (i == 0) ? 16'h1000 : 16'h0000;
      checks++;
      if ({res_idx[i], res_re[i], res_im[i]} !== {4'(i), exp_re, 16'h0000})
        $display("[TB] FAIL dc_bin%0d: got idx %0d %h/%h want idx %0d %h/0000",
                 i, res_idx[i], res_re[i], res_im[i], i, exp_re);
      else passed++;
    end
    checks++;
    if (res_done[15] !== 1'b1 || done_cnt != 1)
      $display("[TB] FAIL dc_done: got done@15=%b pulses=%0d want 1/1", res_done[15], done_cnt);
    else passed++;
  endtask

  task automatic test_nyquist();
    load_nyquist();
    send_frame();
    collect_frame();
    checks++;
    if (timed_out) $display("[TB] FAIL nyquist_timeout: got %0d results want 16", got);
    else passed++;
    for (int i = 0; i < 16; i++) begin
      logic [15:0] exp_re;
      exp_re = (i == 8) ? 16'h1000 : 16'h0000;
      checks++;
      if ({res_idx[i], res_re[i], res_im[i]} !== {4'(i), exp_re, 16'h0000})
        $display("[TB] FAIL nyquist_bin%0d: got idx %0d %h/%h want idx %0d %h/0000",
                 i, res_idx[i], res_re[i], res_im[i], i, exp_re);
      else passed++;
    end
  endtask

  task automatic test_quarter();
    load_impulse(4);
    send_frame();
    collect_frame();
    checks++;
    if (timed_out) $display("[TB] FAIL quarter_timeout: got %0d results want 16", got);
    else passed++;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({res_re[i], res_im[i]} !== quarter_bin(i))
        $display("[TB] FAIL quarter_bin%0d: got %h/%h want %h",
                 i, res_re[i], res_im[i], quarter_bin(i));
      else passed++;
    end
  endtask

  task automatic test_latency();
    load_dc();
    send_frame();
    checks++;
    if (not_ready != 0) $display("[TB] FAIL latency_load_ready: got %0d stalls want 0", not_ready);
    else passed++;
    collect_frame();
    checks++;
    if (first_valid_cyc != t_accept + 32)
      $display("[TB] FAIL latency_first_valid: got cycle %0d want %0d",
               first_valid_cyc, t_accept + 32);
    else passed++;
    checks++;
    if (ready_leak != 0) $display("[TB] FAIL latency_din_ready_low: got %0d high cycles want 0", ready_leak);
    else passed++;
    @(negedge clk);
    checks++;
    if ({din_ready, dout_valid, done} !== 3'b100)
      $display("[TB] FAIL latency_return_idle: got rdy/vld/done %b want 100",
               {din_ready, dout_valid, done});
    else passed++;
  endtask

  task automatic test_back_to_back_backpressure();
    int exp_idx = 0;
    int waited = 0;
    bit stalled = 1'b0;
    load_impulse(4);
    send_frame();
    // Junk samples offered during CALC must be ignored.
    repeat (3) begin
      din_valid = 1'b1;
      din_real  = 16'h7FFF;
      din_imag  = 16'h7FFF;
      @(negedge clk);
    end
    din_valid = 1'b0;
    din_real  = '0;
    din_imag  = '0;
    dout_ready = 1'b1;
    while (exp_idx < 16 && waited < 200) begin
      @(negedge clk);
      waited++;
      if (dout_valid && dout_idx == 4'd5 && !stalled) begin
        dout_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checks++;
          if ({dout_valid, dout_idx, dout_real, dout_imag} !== {1'b1, 4'd5, 16'h0000, 16'hFF00})
            $display("[TB] FAIL stall_hold: got vld %b idx %0d %h/%h want 1 5 0000/ff00",
                     dout_valid, dout_idx, dout_real, dout_imag);
          else passed++;
        end
        dout_ready = 1'b1;
        stalled = 1'b1;
      end
      if (dout_valid) begin
        checks++;
        if ({dout_idx, dout_real, dout_imag} !== {4'(exp_idx), quarter_bin(exp_idx)})
          $display("[TB] FAIL stall_seq%0d: got idx %0d %h/%h want idx %0d %h",
                   exp_idx, dout_idx, dout_real, dout_imag, exp_idx, quarter_bin(exp_idx));
        else passed++;
        exp_idx++;
      end
    end
    checks++;
    if (exp_idx != 16 || !stalled)
      $display("[TB] FAIL stall_count: got %0d results stalled=%b want 16/1", exp_idx, stalled);
    else passed++;
  endtask

  task automatic test_reset_mid_calc();
    int leaks = 0;
    load_dc();
    send_frame();
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({din_ready, dout_valid} !== 2'b10)
      $display("[TB] FAIL midreset_idle: got rdy/vld %b want 10", {din_ready, dout_valid});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (dout_valid || !din_ready) leaks++;
    end
    checks++;
    if (leaks != 0) $display("[TB] FAIL midreset_no_output: got %0d busy cycles want 0", leaks);
    else passed++;
    load_dc();
    send_frame();
    collect_frame();
    for (int i = 0; i < 16; i++) begin
      logic [15:0] exp_re;
      exp_re = (i == 0) ? 16'h1000 : 16'h0000;
      checks++;
      if ({res_idx[i], res_re[i], res_im[i]} !== {4'(i), exp_re, 16'h0000})
        $display("[TB] FAIL midreset_dc_bin%0d: got idx %0d %h/%h want idx %0d %h/0000",
                 i, res_idx[i], res_re[i], res_im[i], i, exp_re);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_nyquist();
    test_quarter();
    test_latency();
    test_back_to_back_backpressure();
    test_reset_mid_calc();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
